map_access_arbiter: RTL and testbench

//  Shares the single combinational tile-map lookup port (5 rows x 100 cols, 15-bit tile: [14:12] block_state, [11:0] RGB444)

---
 rtl/map_pkg.sv | 40 ++++
 rtl/map_col_wrap.sv | 15 +
 rtl/map_access_arbiter.sv | 116 +++++++++++
 tb/tb_map_access_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared tile-map constants, tile field layout, block_state codes and address types.
package map_pkg;
  localparam int MAP_ROWS = 5;
  localparam int MAP_COLS = 100;
  localparam int ROW_W    = 3;
  localparam int COL_W    = 7;
  localparam int TILE_W   = 15;

  localparam int BS_MSB = 14;
  localparam int BS_LSB = 12;
  localparam int R_MSB  = 11;
  localparam int R_LSB  = 8;
  localparam int G_MSB  = 7;
  localparam int G_LSB  = 4;
  localparam int B_MSB  = 3;
  localparam int B_LSB  = 0;

  typedef enum logic [2:0] {
    BLK_EMPTY  = 3'b000,
    BLK_SOLID  = 3'b001,
    BLK_HAZARD = 3'b010
  } blk_state_e;

  typedef enum logic {
    OWN_R0 = 1'b0,
    OWN_R1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } map_addr_t;

  // Empty, black tile returned for rejected addresses.
  localparam logic [TILE_W-1:0] TILE_EMPTY = {BLK_EMPTY, 12'h000};

  function automatic logic addr_oob(input map_addr_t a);
    return (a.row >= ROW_W'(MAP_ROWS)) || (a.col >= COL_W'(MAP_COLS));
  endfunction
endpackage

// File: rtl/map_col_wrap.sv
// Combinational (col + off) mod MAP_COLS; single subtraction, 8-bit intermediate.
module map_col_wrap
  import map_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  input  logic [COL_W-1:0] i_off,
  output logic [COL_W-1:0] o_col
);
  logic [COL_W:0] w_sum;
  logic [COL_W:0] w_sub;

  assign w_sum = {1'b0, i_col} + {1'b0, i_off};
  assign w_sub = w_sum - (COL_W+1)'(MAP_COLS);
  assign o_col = (w_sum >= (COL_W+1)'(MAP_COLS)) ? w_sub[COL_W-1:0] : w_sum[COL_W-1:0];
endmodule

// File: rtl/map_access_arbiter.sv
// Two-requester arbiter for the tile-map port with starvation guard, scroll offset and
// 2-stage addr/data pipeline. Define MAP_ARB_BOUNDS_EN to reject out-of-range addresses.
module map_access_arbiter
  import map_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic [ROW_W-1:0]  r0_row,
  input  logic [COL_W-1:0]  r0_col,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [TILE_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ROW_W-1:0]  r1_row,
  input  logic [COL_W-1:0]  r1_col,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [TILE_W-1:0] r1_rdata,
  input  logic              scroll_step,
  output logic [COL_W-1:0]  scroll_off,
  output logic [ROW_W-1:0]  map_row,
  output logic [COL_W-1:0]  map_col,
  input  logic [TILE_W-1:0] map_data,
  output logic              addr_err
);
  localparam int STAGES = 2;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic [COL_W-1:0]  r_scroll_off;
  logic [STAGES:1]   r_vld_pipe;
  owner_e            r_own1, r_own2;
  logic              r_bad1;
  logic [ROW_W-1:0]  r_map_row;
  logic [COL_W-1:0]  r_map_col;
  logic [TILE_W-1:0] r_r0_rdata, r_r1_rdata;

  logic              w_sel_r1, w_gnt, w_bad;
  map_addr_t         w_addr;
  logic [COL_W-1:0]  w_eff_col;

  // R1 wins when alone, or when it has been blocked STARVE_LIMIT cycles in a row.
  always_comb begin
    w_sel_r1 = r1_req && (!r0_req || (r_wait_cnt == WAIT_W'(STARVE_LIMIT)));
    w_gnt    = r0_req || r1_req;
    w_addr   = w_sel_r1 ? map_addr_t'{row: r1_row, col: r1_col}
                        : map_addr_t'{row: r0_row, col: r0_col};
  end

  assign r0_gnt = r0_req && !w_sel_r1;
  assign r1_gnt = w_sel_r1;

  map_col_wrap u_col_wrap (
    .i_col (w_addr.col),
    .i_off (r_scroll_off),
    .o_col (w_eff_col)
  );

`ifdef MAP_ARB_BOUNDS_EN
  assign w_bad    = addr_oob(w_addr);
  assign addr_err = r_vld_pipe[1] && r_bad1;
`else
  assign w_bad    = 1'b0;
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt   <= '0;
      r_scroll_off <= '0;
      r_vld_pipe   <= '0;
      r_own1       <= OWN_R0;
      r_own2       <= OWN_R0;
      r_bad1       <= 1'b0;
      r_map_row    <= '0;
      r_map_col    <= '0;
      r_r0_rdata   <= '0;
      r_r1_rdata   <= '0;
    end else begin
      if (!r1_req || r1_gnt)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_W'(STARVE_LIMIT))
        r_wait_cnt <= r_wait_cnt + 1'b1;

      if (scroll_step)
        r_scroll_off <= (r_scroll_off == COL_W'(MAP_COLS - 1)) ? '0 : r_scroll_off + 1'b1;

      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_gnt};
      r_own1     <= w_sel_r1 ? OWN_R1 : OWN_R0;
      r_own2     <= r_own1;
      r_bad1     <= w_gnt && w_bad;

      // Bad addresses never reach the map; the port keeps its last address.
      if (w_gnt && !w_bad) begin
        r_map_row <= w_addr.row;
        r_map_col <= w_eff_col;
      end

      if (r_vld_pipe[1]) begin
        if (r_own1 == OWN_R1) r_r1_rdata <= r_bad1 ? TILE_EMPTY : map_data;
        else                  r_r0_rdata <= r_bad1 ? TILE_EMPTY : map_data;
      end
    end
  end

  assign r0_rvalid  = r_vld_pipe[STAGES] && (r_own2 == OWN_R0);
  assign r1_rvalid  = r_vld_pipe[STAGES] && (r_own2 == OWN_R1);
  assign r0_rdata   = r_r0_rdata;
  assign r1_rdata   = r_r1_rdata;
  assign scroll_off = r_scroll_off;
  assign map_row    = r_map_row;
  assign map_col    = r_map_col;
endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed bench for map_access_arbiter; the map is a trivial ROM encoding {row, 5'b0, col}.
module tb_map_access_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r1_req, scroll_step;
  logic [2:0]  r0_row, r1_row;
  logic [6:0]  r0_col, r1_col;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, addr_err;
  logic [14:0] r0_rdata, r1_rdata, map_data;
  logic [6:0]  scroll_off, map_col;
  logic [2:0]  map_row;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  map_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_row(r0_row), .r0_col(r0_col), .r0_gnt(r0_gnt),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_row(r1_row), .r1_col(r1_col), .r1_gnt(r1_gnt),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .scroll_step(scroll_step), .scroll_off(scroll_off),
    .map_row(map_row), .map_col(map_col), .map_data(map_data), .addr_err(addr_err)
  );

  assign map_data = {map_row, 5'b00000, map_col};

  function automatic logic [14:0] tile(input int r, input int c);
    return {3'(r), 5'b00000, 7'(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    r0_req = 0; r1_req = 0; scroll_step = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; idle();
    r0_row = 0; r0_col = 0; r1_row = 0; r1_col = 0;
    repeat (3) tick();
    rst_n = 1;
    #1;
    chk("rst_r0_rvalid", r0_rvalid, 0);
    chk("rst_r1_rvalid", r1_rvalid, 0);
    chk("rst_r0_rdata", r0_rdata, 0);
    chk("rst_r1_rdata", r1_rdata, 0);
    chk("rst_map_row", map_row, 0);
    chk("rst_map_col", map_col, 0);
    chk("rst_scroll", scroll_off, 0);
    chk("rst_addr_err", addr_err, 0);
    tick();

    // 1: single R0 access, 2-cycle latency
    r0_req = 1; r0_row = 2; r0_col = 10;
    #1;
    chk("t1_r0_gnt", r0_gnt, 1);
    chk("t1_r1_gnt", r1_gnt, 0);
    tick(); r0_req = 0;
    chk("t1_map_row", map_row, 2);
    chk("t1_map_col", map_col, 10);
    chk("t1_early_rvalid", r0_rvalid, 0);
    tick();
    chk("t1_rvalid", r0_rvalid, 1);
    chk("t1_rdata", r0_rdata, tile(2, 10));
    chk("t1_r1_rvalid", r1_rvalid, 0);
    tick();
    chk("t1_rvalid_pulse", r0_rvalid, 0);

    // 2: scroll 95, col 10 -> 5, then wrap back to 0
    scroll_step = 1;
    repeat (95) tick();
    scroll_step = 0;
    chk("t2_scroll95", scroll_off, 95);
    r1_req = 1; r1_row = 1; r1_col = 10;
    #1;
    chk("t2_r1_gnt", r1_gnt, 1);
    tick(); r1_req = 0;
    chk("t2_map_row", map_row, 1);
    chk("t2_map_col", map_col, 5);
    tick();
    chk("t2_r1_rvalid", r1_rvalid, 1);
    chk("t2_r1_rdata", r1_rdata, tile(1, 5));
    scroll_step = 1;
    repeat (5) tick();
    scroll_step = 0;
    chk("t2_scroll_wrap", scroll_off, 0);

    // 3: starvation guard
    r0_req = 1; r0_row = 0; r0_col = 0;
    r1_req = 1; r1_row = 3; r1_col = 20;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_r0_wins", r0_gnt, 1);
      chk("t3_r1_blocked", r1_gnt, 0);
      tick();
    end
    #1;
    chk("t3_r1_forced", r1_gnt, 1);
    chk("t3_r0_held", r0_gnt, 0);
    tick();
    #1;
    chk("t3_r0_resume", r0_gnt, 1);
    chk("t3_r1_reblocked", r1_gnt, 0);
    idle();
    repeat (3) tick();

    // 4: back-to-back r0, r1, r0
    r0_req = 1; r0_row = 1; r0_col = 1;
    #1; chk("t4_gnt_a", r0_gnt, 1);
    tick();
    r0_req = 0; r1_req = 1; r1_row = 2; r1_col = 2;
    #1; chk("t4_gnt_b", r1_gnt, 1);
    tick();
    r1_req = 0; r0_req = 1; r0_row = 3; r0_col = 3;
    #1;
    chk("t4_gnt_c", r0_gnt, 1);
    chk("t4_rv_a", r0_rvalid, 1);
    chk("t4_rv_a_r1", r1_rvalid, 0);
    chk("t4_rd_a", r0_rdata, tile(1, 1));
    tick(); idle();
    chk("t4_rv_b", r1_rvalid, 1);
    chk("t4_rv_b_r0", r0_rvalid, 0);
    chk("t4_rd_b", r1_rdata, tile(2, 2));
    tick();
    chk("t4_rv_c", r0_rvalid, 1);
    chk("t4_rv_c_r1", r1_rvalid, 0);
    chk("t4_rd_c", r0_rdata, tile(3, 3));
    tick();
    chk("t4_drained", r0_rvalid, 0);

    // column wrap at the top boundary: col 99 + off 1 -> 0
    scroll_step = 1; tick(); scroll_step = 0;
    chk("wrap_scroll1", scroll_off, 1);
    r0_req = 1; r0_row = 4; r0_col = 99;
    #1; chk("wrap_gnt", r0_gnt, 1);
    tick(); idle();
    chk("wrap_map_row", map_row, 4);
    chk("wrap_map_col", map_col, 0);
    tick();
    chk("wrap_rdata", r0_rdata, tile(4, 0));

    // 5: reset while an access is in flight
    r0_req = 1; r0_row = 3; r0_col = 40;
    tick(); idle();
    #2 rst_n = 0;
    #1;
    chk("t5_scroll_async", scroll_off, 0);
    chk("t5_map_col_async", map_col, 0);
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_r0_rvalid", r0_rvalid, 0);
      chk("t5_r1_rvalid", r1_rvalid, 0);
      chk("t5_r0_rdata", r0_rdata, 0);
      chk("t5_map_row", map_row, 0);
      tick();
    end

    // 6: out-of-range row
    r1_req = 1; r1_row = 5; r1_col = 7;
    #1; chk("t6_r1_gnt", r1_gnt, 1);
    tick(); idle();
`ifdef MAP_ARB_BOUNDS_EN
    chk("t6_addr_err", addr_err, 1);
    chk("t6_map_row_hold", map_row, 0);
    chk("t6_map_col_hold", map_col, 0);
`else
    chk("t6_addr_err", addr_err, 0);
    chk("t6_map_row", map_row, 5);
    chk("t6_map_col", map_col, 7);
`endif
    tick();
    chk("t6_r1_rvalid", r1_rvalid, 1);
    chk("t6_addr_err_pulse", addr_err, 0);
`ifdef MAP_ARB_BOUNDS_EN
    chk("t6_r1_rdata", r1_rdata, 15'h0000);
`else
    chk("t6_r1_rdata", r1_rdata, tile(5, 7));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
